gsens_spi_reader: RTL and testbench

- Upstream feeder for the tilt parser. SPI master (mode 3, 4-wire) that initialises the on-board ADXL345 accelerometer and periodically burst-reads one axis.
- Presents each reading as a 10-bit two's-complement sample plus a one-cycle valid strobe.
- The sample feeds the parser's 10-bit data input directly; the parser consumes it combinationally.

---
 rtl/gsens_spi_reader_if.sv | 27 ++
 rtl/gsens_spi_reader.sv | 178 +++++++++++++++++
 tb/tb_gsens_spi_reader.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/gsens_spi_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : gsens_spi_reader_if
// Brief    : SPI pins and sample outputs of the accelerometer reader.
// Revision : 1.0 - initial release
// ============================================================================
interface gsens_spi_reader_if;
  logic       spi_cs_n;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso;
  logic [9:0] sample;
  logic       sample_valid;
  logic       init_done;
  logic       overrun;

  modport master (
    output spi_cs_n, spi_sclk, spi_mosi, sample, sample_valid, init_done, overrun,
    input  spi_miso
  );

  modport slave (
    input  spi_cs_n, spi_sclk, spi_mosi, sample, sample_valid, init_done, overrun,
    output spi_miso
  );
endinterface
`default_nettype wire

// File: rtl/gsens_spi_reader.sv
`default_nettype none
// ============================================================================
// Module   : gsens_spi_reader
// Brief    : Mode-3 SPI master that configures an ADXL345 and periodically
//            burst-reads one axis into a 10-bit two's-complement sample.
// Revision : 1.0 - initial release
// ============================================================================
module gsens_spi_reader #(
  parameter int         CLK_DIV       = 25,
  parameter int         SAMPLE_PERIOD = 50000,
  parameter logic [7:0] AXIS_REG      = 8'h32
) (
  input  wire logic          clk,
  input  wire logic          rst,
  gsens_spi_reader_if.master bus
);
  localparam int                 c_GAP       = 2 * CLK_DIV;
  localparam int                 c_DIV_W     = $clog2(c_GAP);
  localparam int                 c_PER_W     = $clog2(SAMPLE_PERIOD);
  localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(CLK_DIV - 1);
  localparam logic [c_DIV_W-1:0] c_GAP_LAST  = c_DIV_W'(c_GAP - 1);
  localparam logic [c_PER_W-1:0] c_PER_LAST  = c_PER_W'(SAMPLE_PERIOD - 1);
  localparam logic [15:0]        c_FMT_FRAME = 16'h3100;
  localparam logic [15:0]        c_PWR_FRAME = 16'h2D08;
  localparam logic [7:0]         c_RD_CMD    = 8'hC0 | AXIS_REG;

  typedef enum logic [1:0] {S_INIT_FMT, S_INIT_PWR, S_IDLE, S_READ} state_t;
  typedef enum logic [2:0] {PH_GAP, PH_SETUP, PH_LOW, PH_HIGH, PH_HOLD} phase_t;

  state_t               r_state, w_state;
  phase_t               r_phase, w_phase;
  logic [c_DIV_W-1:0]   r_div, w_div;
  logic [4:0]           r_bits, w_bits;
  logic [23:0]          r_tx, w_tx;
  logic [15:0]          r_rx, w_rx;
  logic [c_PER_W-1:0]   r_per, w_per;
  logic                 r_pending, w_pending;
  logic                 r_cs_n, w_cs_n;
  logic                 r_sclk, w_sclk;
  logic                 r_mosi, w_mosi;
  logic [9:0]           r_sample, w_sample;
  logic                 r_valid, w_valid;
  logic                 r_init_done, w_init_done;
  logic                 r_overrun, w_overrun;
  logic                 w_div_last, w_gap_ok, w_tick, w_start_read;

  assign w_div_last = (r_div == c_DIV_LAST);
  assign w_gap_ok   = (r_div == c_GAP_LAST);
  assign w_tick     = (r_per == c_PER_LAST);

  always_comb begin
    w_state      = r_state;
    w_phase      = r_phase;
    w_div        = r_div + 1'b1;
    w_bits       = r_bits;
    w_tx         = r_tx;
    w_rx         = r_rx;
    w_cs_n       = r_cs_n;
    w_sclk       = r_sclk;
    w_mosi       = r_mosi;
    w_sample     = r_sample;
    w_valid      = 1'b0;
    w_init_done  = r_init_done;
    w_start_read = 1'b0;

    case (r_phase)
      PH_GAP: begin
        // Counter saturates so CS_N high time is at least the full gap.
        w_div = w_gap_ok ? r_div : r_div + 1'b1;
        if (w_gap_ok && (r_state != S_IDLE || r_pending)) begin
          w_phase = PH_SETUP;
          w_div   = '0;
          w_cs_n  = 1'b0;
          case (r_state)
            S_INIT_FMT: begin w_tx = {c_FMT_FRAME, 8'h00}; w_bits = 5'd16; end
            S_INIT_PWR: begin w_tx = {c_PWR_FRAME, 8'h00}; w_bits = 5'd16; end
            default: begin
              w_tx         = {c_RD_CMD, 16'h0000};
              w_bits       = 5'd24;
              w_state      = S_READ;
              w_start_read = 1'b1;
            end
          endcase
        end
      end
      PH_SETUP, PH_HIGH: begin
        if (w_div_last) begin
          w_div = '0;
          if (r_bits == 5'd0) begin
            w_phase = PH_HOLD;
          end else begin
            w_phase = PH_LOW;
            w_sclk  = 1'b0;
            w_mosi  = r_tx[23];
            w_tx    = {r_tx[22:0], 1'b0};
          end
        end
      end
      PH_LOW: begin
        if (w_div_last) begin
          w_phase = PH_HIGH;
          w_div   = '0;
          w_sclk  = 1'b1;
          w_rx    = {r_rx[14:0], bus.spi_miso};
          w_bits  = r_bits - 5'd1;
        end
      end
      PH_HOLD: begin
        if (w_div_last) begin
          w_phase = PH_GAP;
          w_div   = '0;
          w_cs_n  = 1'b1;
          w_mosi  = 1'b0;
          case (r_state)
            S_INIT_FMT: w_state = S_INIT_PWR;
            S_INIT_PWR: begin w_state = S_IDLE; w_init_done = 1'b1; end
            default: begin
              // r_rx[15:8] = DATA0, r_rx[7:0] = DATA1
              w_state  = S_IDLE;
              w_sample = {r_rx[1:0], r_rx[15:8]};
              w_valid  = 1'b1;
            end
          endcase
        end
      end
      default: w_phase = PH_GAP;
    endcase

    w_per     = w_tick ? '0 : r_per + 1'b1;
    w_pending = (r_pending && !w_start_read) || (w_tick && r_init_done);
    w_overrun = r_overrun || (w_tick && r_pending);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_INIT_FMT;
      r_phase     <= PH_GAP;
      r_div       <= '0;
      r_bits      <= '0;
      r_tx        <= '0;
      r_rx        <= '0;
      r_per       <= '0;
      r_pending   <= 1'b0;
      r_cs_n      <= 1'b1;
      r_sclk      <= 1'b1;
      r_mosi      <= 1'b0;
      r_sample    <= '0;
      r_valid     <= 1'b0;
      r_init_done <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_phase     <= w_phase;
      r_div       <= w_div;
      r_bits      <= w_bits;
      r_tx        <= w_tx;
      r_rx        <= w_rx;
      r_per       <= w_per;
      r_pending   <= w_pending;
      r_cs_n      <= w_cs_n;
      r_sclk      <= w_sclk;
      r_mosi      <= w_mosi;
      r_sample    <= w_sample;
      r_valid     <= w_valid;
      r_init_done <= w_init_done;
      r_overrun   <= w_overrun;
    end
  end

  assign bus.spi_cs_n     = r_cs_n;
  assign bus.spi_sclk     = r_sclk;
  assign bus.spi_mosi     = r_mosi;
  assign bus.sample       = r_sample;
  assign bus.sample_valid = r_valid;
  assign bus.init_done    = r_init_done;
  assign bus.overrun      = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_gsens_spi_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_gsens_spi_reader
// Brief    : Three reader instances (main, overrun, fast SCLK) against an
//            ADXL345 slave model with a sample scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gsens_spi_reader;
  typedef struct {
    logic [7:0] d0;
    logic [7:0] d1;
    logic [9:0] exp;
  } vec_t;

  vec_t       vecs [4];
  logic       clk = 1'b0;
  logic [2:0] rst = 3'b111;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int CD        = (g == 2) ? 2 : 25;
    localparam int SP        = (g == 0) ? 2000 : 1000;
    localparam int RD_LEN    = 25 * 2 * CD;
    localparam int EXP_SPACE = (SP > RD_LEN + 2 * CD) ? SP : RD_LEN + 2 * CD;

    gsens_spi_reader_if bus ();

    gsens_spi_reader #(
      .CLK_DIV      (CD),
      .SAMPLE_PERIOD(SP),
      .AXIS_REG     (8'h32)
    ) u_dut (
      .clk(clk),
      .rst(rst[g]),
      .bus(bus)
    );

    logic [9:0]  sb [$];
    logic [23:0] mosi_sh = '0;
    logic [7:0]  d0 = '0;
    logic [7:0]  d1 = '0;
    int cyc = 0, nval = 0, k = 0, fcnt = 0, rcnt = 0, low_len = 0, last_rise = 0;
    int vidx = (g == 2) ? 3 : 0;
    int last_read_start = -1;
    bit aborted = 0, per_checked = 0, prev_cs = 1, prev_sclk = 1, prev_valid = 0, ovr_seen = 0;

    always @(negedge clk) begin
      cyc++;
      if (rst[g]) begin
        if (!bus.spi_cs_n) aborted = 1;
        k = 0;
        sb.delete();
        last_read_start = -1;
        ovr_seen = 0;
        bus.spi_miso = 1'b0;
      end else begin
        if (prev_cs && !bus.spi_cs_n) begin
          fcnt = 0; rcnt = 0; mosi_sh = '0; low_len = 0;
          if (k >= 2) begin
            if (last_read_start >= 0)
              chk($sformatf("dut%0d read spacing", g), cyc - last_read_start, EXP_SPACE);
            if (ovr_seen) chk($sformatf("dut%0d overrun sticky", g), int'(bus.overrun), 1);
            last_read_start = cyc;
          end
        end
        if (!bus.spi_cs_n) begin
          low_len++;
          if (prev_sclk && !bus.spi_sclk) begin
            // Slave shifts out on the falling edge: 8 command slots, DATA0, DATA1.
            if (fcnt < 8)       bus.spi_miso = 1'b0;
            else if (fcnt < 16) bus.spi_miso = d0[3'(15 - fcnt)];
            else                bus.spi_miso = d1[3'(23 - fcnt)];
            fcnt++;
          end
          if (!prev_sclk && bus.spi_sclk) begin
            mosi_sh = {mosi_sh[22:0], bus.spi_mosi};
            rcnt++;
            if (rcnt == 2 && !per_checked) begin
              chk($sformatf("dut%0d sclk period", g), cyc - last_rise, 2 * CD);
              per_checked = 1;
            end
            last_rise = cyc;
            if (rcnt == 8 && mosi_sh[7]) begin
              d0 = vecs[vidx].d0;
              d1 = vecs[vidx].d1;
              sb.push_back(vecs[vidx].exp);
              vidx = (g == 2) ? 3 : (vidx + 1) % 4;
            end
          end
        end
        if (!prev_cs && bus.spi_cs_n) begin
          if (aborted) begin
            aborted = 0;
          end else begin
            if (k < 2) begin
              chk($sformatf("dut%0d write bits", g), rcnt, 16);
              chk($sformatf("dut%0d write data", g), int'(mosi_sh[15:0]), (k == 0) ? 16'h3100 : 16'h2D08);
              chk($sformatf("dut%0d write cs low", g), low_len, 17 * 2 * CD);
              chk($sformatf("dut%0d init_done", g), int'(bus.init_done), k);
            end else begin
              chk($sformatf("dut%0d read bits", g), rcnt, 24);
              chk($sformatf("dut%0d read cmd", g), int'(mosi_sh[23:16]), 8'hF2);
              chk($sformatf("dut%0d read cs low", g), low_len, RD_LEN);
              chk($sformatf("dut%0d valid at cs rise", g), int'(bus.sample_valid), 1);
            end
            k++;
          end
        end
        if (bus.sample_valid) begin
          chk($sformatf("dut%0d valid has request", g), int'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            chk($sformatf("dut%0d sample", g), int'(bus.sample), int'(sb.pop_front()));
            nval++;
          end
        end
        if (prev_valid) chk($sformatf("dut%0d valid width", g), int'(bus.sample_valid), 0);
        if (bus.overrun) ovr_seen = 1;
      end
      prev_cs    = bus.spi_cs_n;
      prev_sclk  = bus.spi_sclk;
      prev_valid = bus.sample_valid;
    end
  end

  task automatic wait_dut0_reads(input int n, input int budget);
    int c = 0;
    while (g_inst[0].nval < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("dut0 read count", g_inst[0].nval, n);
  endtask

  initial begin
    int c;
    vecs[0] = '{8'h20, 8'hFB, 10'h320};
    vecs[1] = '{8'hFF, 8'h01, 10'h1FF};
    vecs[2] = '{8'h00, 8'h02, 10'h200};
    vecs[3] = '{8'h55, 8'hFD, 10'h155};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset cs_n", int'(g_inst[0].bus.spi_cs_n), 1);
    chk("reset sclk", int'(g_inst[0].bus.spi_sclk), 1);
    chk("reset mosi", int'(g_inst[0].bus.spi_mosi), 0);
    chk("reset sample", int'(g_inst[0].bus.sample), 0);
    chk("reset valid", int'(g_inst[0].bus.sample_valid), 0);
    chk("reset init_done", int'(g_inst[0].bus.init_done), 0);
    chk("reset overrun", int'(g_inst[0].bus.overrun), 0);
    @(posedge clk);
    #1 rst = 3'b000;

    for (int i = 0; i < 3; i++) wait_dut0_reads(i + 1, 4000);

    // Abort a read frame around bit 10 with a single-cycle reset.
    c = 0;
    while (!(g_inst[0].k >= 2 && !g_inst[0].bus.spi_cs_n && g_inst[0].fcnt == 10) && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk("reach read bit 10", int'(c < 3000), 1);
    @(posedge clk);
    #1 rst[0] = 1'b1;
    @(posedge clk);
    #1 rst[0] = 1'b0;
    @(negedge clk);
    chk("abort cs_n", int'(g_inst[0].bus.spi_cs_n), 1);
    chk("abort sclk", int'(g_inst[0].bus.spi_sclk), 1);
    chk("abort init_done", int'(g_inst[0].bus.init_done), 0);
    chk("abort sample", int'(g_inst[0].bus.sample), 0);

    wait_dut0_reads(4, 6000);
    chk("dut0 reinit done", int'(g_inst[0].bus.init_done), 1);
    chk("dut0 overrun", int'(g_inst[0].bus.overrun), 0);
    chk("dut1 overrun", int'(g_inst[1].bus.overrun), 1);
    chk("dut2 overrun", int'(g_inst[2].bus.overrun), 0);
    chk("dut1 enough reads", int'(g_inst[1].nval >= 5), 1);
    chk("dut2 enough reads", int'(g_inst[2].nval >= 5), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
